tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesters; legal range 2..8.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on rising edge.
REQ-003 SHALL have port reset_, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port req, input, NREQ bits: per-requester transmit request; level, held until ack.
REQ-005 SHALL have port req_data, input, 8*NREQ bits: byte i on bits [8i+7:8i]; stable while req[i]=1.
REQ-006 SHALL have port ack, output, NREQ bits: one-cycle pulse when a requester's byte is taken.
REQ-007 SHALL have port lock, input, NREQ bits: per-requester burst lock; present only with TX_ARB_LOCK_EN.
REQ-008 SHALL have port tx_ready, input, 1 bit: transmitter idle, from the UART transmitter.
REQ-009 SHALL have port txdata, output, 8 bits: byte to the transmitter.
REQ-010 SHALL have port tx_enable, output, 1 bit: one-cycle sample strobe to the transmitter.
REQ-011 SHALL have port grant_id, output, 3 bits: index of the current or last granted requester.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except ST_IDLE.

Function
REQ-013 SHALL implement states ST_IDLE, ST_ISSUE, ST_WAIT_BUSY and ST_WAIT_DONE.
REQ-014 ST_IDLE -> ST_ISSUE SHALL occur when tx_ready=1 and |req; winner index goes to grant_id and its byte to txdata on that edge.
REQ-015 ST_IDLE SHALL hold while tx_ready=0 or req=0; with req=0, no ack or tx_enable SHALL be issued.
REQ-016 In ST_ISSUE, tx_enable=1 and ack[grant_id]=1 for exactly one cycle; next state SHALL be ST_WAIT_BUSY.
REQ-017 Latency SHALL be: req sampled high in ST_IDLE at edge N gives tx_enable and ack high during cycle N+1.
REQ-018 ST_WAIT_BUSY SHALL move to ST_WAIT_DONE when tx_ready=0.
REQ-019 ST_WAIT_DONE SHALL move to ST_IDLE when tx_ready=1, and the round-robin pointer SHALL be updated to grant_id+1 mod NREQ on that edge.
REQ-020 Winner SHALL be the first asserted req at or after the pointer, searching upward with wrap from NREQ-1 to 0.
REQ-021 req changes outside ST_IDLE SHALL be ignored; a req dropped before ack SHALL lose its slot with no ack.
REQ-022 ack, tx_enable SHALL never be high in the same cycle for more than one requester; at most one byte is in flight.
REQ-023 txdata SHALL hold its value until the next ST_IDLE -> ST_ISSUE edge.
REQ-024 Requester that receives ack and keeps req high SHALL be treated as a new request for its next byte.

Reset
REQ-025 On reset_=0: state ST_IDLE, pointer 0, grant_id 0, txdata 8'h00, tx_enable 0, ack 0, busy 0, lock owner invalid.
REQ-026 Reset mid-frame SHALL abort the sequence immediately; the pending byte SHALL NOT be acked or re-issued after reset.

Configuration
REQ-027 With TX_ARB_LOCK_EN defined: at the ST_WAIT_DONE -> ST_IDLE edge, if lock[grant_id]=1, that requester becomes lock owner and the pointer SHALL NOT advance.
REQ-028 With TX_ARB_LOCK_EN defined: while the owner is valid and lock[owner]=1, only req[owner] SHALL be eligible; the owner SHALL be released when lock[owner]=0 is seen in ST_IDLE, and normal round-robin resumes from owner+1.
REQ-029 Without TX_ARB_LOCK_EN: port lock and lock-owner logic SHALL be absent; behaviour is pure round-robin.

Structure
REQ-030 Package tx_arb_pkg SHALL hold the state encoding (2 bits, ST_IDLE=0 ... ST_WAIT_DONE=3) and max-NREQ constant 8.
REQ-031 Round-robin winner selection SHALL be a sub-module rr_pick (inputs: req vector, pointer; outputs: winner index, valid), purely combinational.

Verification
REQ-032 Single req[2]=1, data 8'hA5, tx_ready=1 -> tx_enable and ack[2] one cycle later, txdata=8'hA5, grant_id=2.
REQ-033 req=4'b1111 held for 4 frames with pointer 0 -> grant order 0,1,2,3, one ack each, no overlap.
REQ-034 tx_ready=0 with req[1]=1 -> no tx_enable until tx_ready rises, then tx_enable one cycle later.
REQ-035 TX_ARB_LOCK_EN, lock[3]=1, req=4'b1001 for 3 frames -> grants 3,3,3; drop lock[3] -> next grant 0.
REQ-036 reset_ pulsed low during ST_WAIT_DONE -> busy=0, tx_enable=0, txdata=8'h00 immediately; next grant starts from requester 0.
REQ-037 req[0] dropped in ST_WAIT_BUSY while req[1] held -> no ack[0], next grant 1.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared definitions for the transmit arbiter.
//   tx_arb_state_e : 2-bit FSM state encoding (ST_IDLE=0 .. ST_WAIT_DONE=3)
//   MAX_NREQ       : largest supported requester count
//   IDX_W          : width of a requester index
//   idx_inc()      : requester index + 1, wrapping at the live requester count
package tx_arb_pkg;

   localparam int MAX_NREQ = 8;
   localparam int IDX_W    = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_arb_state_e;

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx, input int n);
      logic [IDX_W-1:0] nxt;
      nxt = idx + 3'd1;
      if (int'(idx) >= n - 1) nxt = '0;
      return nxt;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search.
//   req_i : request vector (NREQ bits)
//   ptr_i : search start index (must be < NREQ)
//   win_o : index of first set request at or above ptr_i, wrapping to 0
//   vld_o : at least one request is set
module rr_pick
   import tx_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] win_o,
   output logic             vld_o
);

   // Offsets are scanned from the farthest down to zero so that the closest
   // hit to the pointer is the last (and therefore final) assignment.
   always_comb begin
      win_o = '0;
      vld_o = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_i[i] && (i == (int'(ptr_i) + k) % NREQ)) begin
               win_o = IDX_W'(i);
               vld_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter feeding single bytes from NREQ requesters
// into a UART transmitter, one byte in flight at a time.
//
// Optional feature: define TX_ARB_LOCK_EN to add the per-requester burst lock.
//
// Ports
//   clk       : clock, rising edge
//   reset_    : asynchronous active-low reset
//   req       : per-requester transmit request (level, held until ack)
//   req_data  : byte i on bits [8i+7:8i]
//   ack       : one-cycle pulse to the requester whose byte was taken
//   lock      : per-requester burst lock (TX_ARB_LOCK_EN only)
//   tx_ready  : transmitter idle
//   txdata    : byte to the transmitter, held until the next grant
//   tx_enable : one-cycle sample strobe to the transmitter
//   grant_id  : index of the current or last granted requester
//   busy      : high in every state except ST_IDLE
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for tx_ready and an eligible request
// ST_ISSUE     | strobe tx_enable and ack the granted requester
// ST_WAIT_BUSY | waiting for the transmitter to drop tx_ready
// ST_WAIT_DONE | waiting for tx_ready to return; pointer advances on exit
module tx_arbiter
   import tx_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   ack,
`ifdef TX_ARB_LOCK_EN
   input  logic [NREQ-1:0]   lock,
`endif
   input  logic              tx_ready,
   output logic [7:0]        txdata,
   output logic              tx_enable,
   output logic [2:0]        grant_id,
   output logic              busy
);

   tx_arb_state_e    state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [7:0]       txdata_q, txdata_d;
   logic [IDX_W-1:0] pick_ptr;
   logic [IDX_W-1:0] win;
   logic             win_vld;
   logic [7:0]       win_byte;
   logic [NREQ-1:0]  elig;

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .req_i (elig),
      .ptr_i (pick_ptr),
      .win_o (win),
      .vld_o (win_vld)
   );

   always_comb begin
      win_byte = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IDX_W'(i)) win_byte = req_data[8*i +: 8];
      end
   end

`ifdef TX_ARB_LOCK_EN
   logic [IDX_W-1:0] owner_q, owner_d;
   logic             owner_vld_q, owner_vld_d;
   logic             owner_lock;
   logic             grant_lock;

   always_comb begin
      owner_lock = 1'b0;
      grant_lock = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner_q == IDX_W'(i)) owner_lock = lock[i];
         if (grant_q == IDX_W'(i)) grant_lock = lock[i];
      end
   end

   // A locked owner masks everyone else. Once its lock drops, the search
   // starts just past the owner in the same cycle the release is seen.
   always_comb begin
      elig     = req;
      pick_ptr = ptr_q;
      if (owner_vld_q && owner_lock) begin
         elig = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IDX_W'(i)) elig[i] = req[i];
         end
      end else if (owner_vld_q) begin
         pick_ptr = idx_inc(owner_q, NREQ);
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
      end
   end
`else
   assign elig     = req;
   assign pick_ptr = ptr_q;
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      txdata_d = txdata_q;
`ifdef TX_ARB_LOCK_EN
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef TX_ARB_LOCK_EN
            if (owner_vld_q && !owner_lock) begin
               owner_vld_d = 1'b0;
               ptr_d       = pick_ptr;
            end
`endif
            if (tx_ready && win_vld) begin
               state_d  = ST_ISSUE;
               grant_d  = win;
               txdata_d = win_byte;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!tx_ready) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (tx_ready) begin
               state_d = ST_IDLE;
               ptr_d   = idx_inc(grant_q, NREQ);
`ifdef TX_ARB_LOCK_EN
               owner_d     = grant_q;
               owner_vld_d = grant_lock;
               if (grant_lock) ptr_d = ptr_q;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         txdata_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         txdata_q <= txdata_d;
      end
   end

   assign tx_enable = (state_q == ST_ISSUE);
   assign busy      = (state_q != ST_IDLE);
   assign txdata    = txdata_q;
   assign grant_id  = grant_q;

   always_comb begin
      ack = '0;
      for (int i = 0; i < NREQ; i++) begin
         ack[i] = tx_enable && (grant_q == IDX_W'(i));
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: self-checking bench for tx_arbiter (NREQ=4).
// Directed frame table, multi-cycle corner sequences, then randomized traffic
// against a frame-level round-robin model. The burst-lock sequence is built
// only when TX_ARB_LOCK_EN is defined.
module tb_tx_arbiter;

   localparam int N = 4;
   localparam logic [31:0] DATA = 32'h44A5_2211;

   logic           clk = 1'b0;
   logic           reset_ = 1'b0;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   ack;
   logic           tx_ready = 1'b0;
   logic [7:0]     txdata;
   logic           tx_enable;
   logic [2:0]     grant_id;
   logic           busy;
`ifdef TX_ARB_LOCK_EN
   logic [N-1:0]   lock = '0;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   tx_arbiter #(.NREQ(N)) dut (
      .clk       (clk),
      .reset_    (reset_),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
`ifdef TX_ARB_LOCK_EN
      .lock      (lock),
`endif
      .tx_ready  (tx_ready),
      .txdata    (txdata),
      .tx_enable (tx_enable),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   typedef struct {
      logic [N-1:0] req;
      int           gnt;
      logic [7:0]   dbyte;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] onehot(input int i);
      logic [31:0] v;
      v = 32'd1 << i;
      return v;
   endfunction

   // First requester with a pending byte at or after p, wrapping.
   function automatic int rr_model(input logic [N-1:0] r, input int p);
      for (int off = 0; off < N; off++) begin
         if (r[(p + off) % N]) return (p + off) % N;
      end
      return -1;
   endfunction

   task automatic tail();
      req = '0;
      cyc();
      chk("pulse_tx_enable", 32'(tx_enable), 32'd0);
      chk("pulse_ack", 32'(ack), 32'd0);
      tx_ready = 1'b0;
      cyc();
      tx_ready = 1'b1;
      cyc();
      chk("busy_after_frame", 32'(busy), 32'd0);
   endtask

   task automatic frame(input logic [N-1:0] r, input int exp_g, input logic [7:0] exp_b, input int wait_n);
      req      = r;
      req_data = DATA;
      tx_ready = (wait_n == 0);
      for (int k = 0; k < wait_n; k++) begin
         cyc();
         chk("stall_tx_enable", 32'(tx_enable), 32'd0);
         chk("stall_busy", 32'(busy), 32'd0);
      end
      tx_ready = 1'b1;
      cyc();
      chk("tx_enable", 32'(tx_enable), 32'd1);
      chk("ack", 32'(ack), onehot(exp_g));
      chk("grant_id", 32'(grant_id), 32'(exp_g));
      chk("txdata", 32'(txdata), 32'(exp_b));
      chk("busy_issue", 32'(busy), 32'd1);
      tail();
      chk("txdata_hold", 32'(txdata), 32'(exp_b));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_tx_enable"}, 32'(tx_enable), 32'd0);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
      chk({tag, "_txdata"}, 32'(txdata), 32'd0);
      chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
   endtask

   logic [N-1:0]   pend;
   logic [7:0]     bytes[N];
   int             ptr_m;
   bit             free_m, skip_m, low_m;
   logic [7:0]     last_tx;
   bit             tx_pend;
   int             lat, lowc;

   initial begin
      tbl[0]  = '{4'b0100, 2, 8'hA5};
      tbl[1]  = '{4'b1111, 3, 8'h44};
      tbl[2]  = '{4'b1111, 0, 8'h11};
      tbl[3]  = '{4'b1111, 1, 8'h22};
      tbl[4]  = '{4'b1111, 2, 8'hA5};
      tbl[5]  = '{4'b1111, 3, 8'h44};
      tbl[6]  = '{4'b0011, 0, 8'h11};
      tbl[7]  = '{4'b0001, 0, 8'h11};
      tbl[8]  = '{4'b1000, 3, 8'h44};
      tbl[9]  = '{4'b0110, 1, 8'h22};
      tbl[10] = '{4'b0011, 0, 8'h11};
      tbl[11] = '{4'b1100, 2, 8'hA5};
      tbl[12] = '{4'b0101, 0, 8'h11};

      #12;
      check_reset_vals("reset");
      @(negedge clk);
      reset_ = 1'b1;

      for (int t = 0; t < 13; t++) frame(tbl[t].req, tbl[t].gnt, tbl[t].dbyte, 0);

      // No request: nothing issued even with tx_ready high.
      req = '0;
      tx_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("idle_tx_enable", 32'(tx_enable), 32'd0);
         chk("idle_ack", 32'(ack), 32'd0);
      end

      // Transmitter not ready: request waits, then issues one cycle after ready.
      frame(4'b0010, 1, 8'h22, 4);
      frame(4'b0100, 2, 8'hA5, 0);

      // req[0] dropped while a frame is in flight loses its slot.
      req = 4'b1011;
      tx_ready = 1'b1;
      cyc();
      chk("drop_first_grant", 32'(grant_id), 32'd3);
      chk("drop_first_ack", 32'(ack), 32'h8);
      req = 4'b0011;
      cyc();
      req = 4'b0010;
      tx_ready = 1'b0;
      cyc();
      chk("drop_ack_quiet", 32'(ack), 32'd0);
      tx_ready = 1'b1;
      cyc();
      chk("drop_busy_low", 32'(busy), 32'd0);
      cyc();
      chk("drop_next_tx_enable", 32'(tx_enable), 32'd1);
      chk("drop_next_grant", 32'(grant_id), 32'd1);
      chk("drop_next_ack", 32'(ack), 32'h2);
      tail();

      // Reset in ST_WAIT_DONE aborts the frame and restarts the pointer at 0.
      req = 4'b0010;
      tx_ready = 1'b1;
      cyc();
      chk("prerst_grant", 32'(grant_id), 32'd1);
      req = 4'b1001;
      cyc();
      tx_ready = 1'b0;
      cyc();
      chk("prerst_busy", 32'(busy), 32'd1);
      reset_ = 1'b0;
      #1;
      check_reset_vals("midrst");
      tx_ready = 1'b1;
      @(negedge clk);
      reset_ = 1'b1;
      cyc();
      chk("postrst_tx_enable", 32'(tx_enable), 32'd1);
      chk("postrst_grant", 32'(grant_id), 32'd0);
      chk("postrst_ack", 32'(ack), 32'h1);
      chk("postrst_txdata", 32'(txdata), 32'h11);
      tail();

`ifdef TX_ARB_LOCK_EN
      reset_ = 1'b0;
      cyc();
      @(negedge clk);
      reset_ = 1'b1;
      frame(4'b0100, 2, 8'hA5, 0);
      lock = 4'b1000;
      for (int k = 0; k < 3; k++) frame(4'b1001, 3, 8'h44, 0);
      lock = 4'b0000;
      frame(4'b1001, 0, 8'h11, 0);
`endif

      // Randomized traffic against the frame-level model.
      req = '0;
      tx_ready = 1'b1;
      reset_ = 1'b0;
      cyc();
      check_reset_vals("rnd_reset");
      @(negedge clk);
      reset_ = 1'b1;
      pend = '0;
      for (int i = 0; i < N; i++) bytes[i] = '0;
      ptr_m = 0;
      free_m = 1'b1;
      skip_m = 1'b0;
      low_m = 1'b0;
      last_tx = '0;
      tx_pend = 1'b0;
      lat = 0;
      lowc = 0;
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0]   r_s;
         logic [8*N-1:0] d_s;
         logic           rdy_s;
         bit             exp_en;
         int             w;
         r_s   = req;
         d_s   = req_data;
         rdy_s = tx_ready;
         cyc();
         exp_en = 1'b0;
         if (free_m) begin
            exp_en = (r_s != '0) && rdy_s;
         end else if (skip_m) begin
            skip_m = 1'b0;
         end else if (!low_m) begin
            if (!rdy_s) low_m = 1'b1;
         end else if (rdy_s) begin
            free_m = 1'b1;
            low_m  = 1'b0;
         end
         chk("rnd_tx_enable", 32'(tx_enable), 32'(exp_en));
         if (exp_en) begin
            w = rr_model(r_s, ptr_m);
            chk("rnd_grant", 32'(grant_id), 32'(w));
            chk("rnd_ack", 32'(ack), onehot(w));
            chk("rnd_txdata", 32'(txdata), 32'(d_s[8*w +: 8]));
            last_tx = d_s[8*w +: 8];
            ptr_m   = (w + 1) % N;
            pend[w] = 1'b0;
            free_m  = 1'b0;
            skip_m  = 1'b1;
         end else begin
            chk("rnd_ack_quiet", 32'(ack), 32'd0);
            chk("rnd_txdata_hold", 32'(txdata), 32'(last_tx));
         end

         if (tx_enable) begin
            tx_pend = 1'b1;
            lat  = $urandom_range(0, 2);
            lowc = $urandom_range(2, 5);
         end
         if (tx_pend) begin
            if (lat > 0) begin
               lat--;
               tx_ready = 1'b1;
            end else if (lowc > 0) begin
               lowc--;
               tx_ready = 1'b0;
            end else begin
               tx_ready = 1'b1;
               tx_pend  = 1'b0;
            end
         end else begin
            tx_ready = ($urandom_range(0, 7) != 0);
         end

         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 3) == 0)) begin
               pend[i]  = 1'b1;
               bytes[i] = 8'($urandom);
            end
            req_data[8*i +: 8] = bytes[i];
         end
         req = pend;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
